match_tracker: RTL and testbench

MATCH_TRACKER -- requirements
Module: match_tracker

---
 rtl/match_pkg.sv | 28 ++
 rtl/score_counter.sv | 39 +++
 rtl/match_tracker.sv | 136 +++++++++++++
 tb/tb_match_tracker.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/match_pkg.sv
// Shared definitions for the match tracker: FSM encoding, game-state codes
// and the width helpers used to size score and player-index fields.
package match_pkg;

  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_HOLD = 2'd1,
    ST_OVER = 2'd2
  } fsm_state_e;

  localparam int unsigned GS_IDLE   = 0;
  localparam int unsigned GS_WIN_P0 = 5;
  localparam int unsigned GS_WIN_P1 = 6;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

  function automatic int unsigned clog2_min1(input int unsigned value);
    int unsigned r;
    r = clog2(value);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/score_counter.sv
// Per-player saturating round-win counter with synchronous clear.
module score_counter
  import match_pkg::*;
#(
  parameter  int unsigned MAX = 3,
  localparam int unsigned W   = clog2_min1(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         at_max
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign at_max = (count_q == W'(MAX));
  assign count  = count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !at_max) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/match_tracker.sv
// Tracks round wins per player from the game-controller state, scoring each
// win episode once and declaring a champion at ROUNDS_TO_WIN.
module match_tracker
  import match_pkg::*;
#(
  parameter  int unsigned NUM_PLAYERS    = 2,
  parameter  int unsigned STATE_W        = 3,
  parameter  int unsigned WIN_STATE_BASE = GS_WIN_P0,
  parameter  int unsigned ROUNDS_TO_WIN  = 3,
  localparam int unsigned SCORE_W        = clog2_min1(ROUNDS_TO_WIN + 1),
  localparam int unsigned PIDX_W         = clog2_min1(NUM_PLAYERS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [STATE_W-1:0]             state,
  input  logic                           new_match,
  output logic [NUM_PLAYERS-1:0]         winner,
  output logic                           round_pulse,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
  output logic                           match_over,
  output logic [PIDX_W-1:0]              champion
);

  if (WIN_STATE_BASE + NUM_PLAYERS - 1 > (2 ** STATE_W) - 1) begin : g_chk_codes
    $fatal(1, "match_tracker: win codes do not fit in STATE_W bits");
  end
  if (NUM_PLAYERS < 2 || NUM_PLAYERS > 8) begin : g_chk_players
    $fatal(1, "match_tracker: NUM_PLAYERS must be 2..8");
  end
  if (ROUNDS_TO_WIN < 1 || ROUNDS_TO_WIN > 15) begin : g_chk_rounds
    $fatal(1, "match_tracker: ROUNDS_TO_WIN must be 1..15");
  end

  fsm_state_e                     fsm_q, fsm_d;
  logic [NUM_PLAYERS-1:0]         winner_q;
  logic                           round_pulse_q, round_pulse_d;
  logic                           match_over_q, match_over_d;
  logic [PIDX_W-1:0]              champion_q, champion_d;

  logic [NUM_PLAYERS-1:0]         win_onehot;
  logic [PIDX_W-1:0]              win_idx;
  logic                           is_win;
  logic [NUM_PLAYERS-1:0]         near_max;
  logic [NUM_PLAYERS-1:0]         at_max_vec;
  logic [NUM_PLAYERS-1:0]         inc_vec;
  logic                           clr;
  logic [NUM_PLAYERS*SCORE_W-1:0] scores_all;

  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
      if (state == STATE_W'(WIN_STATE_BASE + p)) begin
        win_onehot[p] = 1'b1;
        win_idx       = PIDX_W'(p);
      end
    end
  end

  assign is_win = |win_onehot;

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    score_counter #(
      .MAX (ROUNDS_TO_WIN)
    ) u_score (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr),
      .inc    (inc_vec[p]),
      .count  (scores_all[p*SCORE_W +: SCORE_W]),
      .at_max (at_max_vec[p])
    );
    assign near_max[p] = (scores_all[p*SCORE_W +: SCORE_W] == SCORE_W'(ROUNDS_TO_WIN - 1));
  end

  // new_match wins over any scoring in the same cycle; the FSM lands in HOLD
  // when a win code is already present so that episode never scores.
  always_comb begin
    fsm_d         = fsm_q;
    round_pulse_d = 1'b0;
    match_over_d  = match_over_q;
    champion_d    = champion_q;
    inc_vec       = '0;
    clr           = 1'b0;
    if (new_match) begin
      clr          = 1'b1;
      match_over_d = 1'b0;
      champion_d   = '0;
      fsm_d        = is_win ? ST_HOLD : ST_PLAY;
    end else begin
      unique case (fsm_q)
        ST_PLAY: begin
          if (is_win) begin
            inc_vec       = win_onehot & ~at_max_vec;
            round_pulse_d = 1'b1;
            if (|(win_onehot & near_max)) begin
              fsm_d        = ST_OVER;
              match_over_d = 1'b1;
              champion_d   = win_idx;
            end else begin
              fsm_d = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (!is_win) fsm_d = ST_PLAY;
        end
        ST_OVER: ;
        default: fsm_d = ST_PLAY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q         <= ST_PLAY;
      winner_q      <= '0;
      round_pulse_q <= 1'b0;
      match_over_q  <= 1'b0;
      champion_q    <= '0;
    end else begin
      fsm_q         <= fsm_d;
      winner_q      <= win_onehot;
      round_pulse_q <= round_pulse_d;
      match_over_q  <= match_over_d;
      champion_q    <= champion_d;
    end
  end

  assign winner      = winner_q;
  assign round_pulse = round_pulse_q;
  assign scores      = scores_all;
  assign match_over  = match_over_q;
  assign champion    = champion_q;

endmodule

// File: tb/tb_match_tracker.sv
// Directed bench for match_tracker: default 2-player instance plus a
// 4-player instance with overridden codes and a shorter match.
module tb_match_tracker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, new_match;
  logic [2:0] state;
  logic [1:0] winner;
  logic       round_pulse, match_over;
  logic [3:0] scores;
  logic [0:0] champion;

  logic       rst4, new_match4;
  logic [3:0] state4;
  logic [3:0] winner4;
  logic       round_pulse4, match_over4;
  logic [7:0] scores4;
  logic [1:0] champion4;

  int unsigned total  = 0;
  int unsigned passed = 0;

  match_tracker dut (
    .clk         (clk),
    .rst         (rst),
    .state       (state),
    .new_match   (new_match),
    .winner      (winner),
    .round_pulse (round_pulse),
    .scores      (scores),
    .match_over  (match_over),
    .champion    (champion)
  );

  match_tracker #(
    .NUM_PLAYERS    (4),
    .STATE_W        (4),
    .WIN_STATE_BASE (8),
    .ROUNDS_TO_WIN  (2)
  ) dut4 (
    .clk         (clk),
    .rst         (rst4),
    .state       (state4),
    .new_match   (new_match4),
    .winner      (winner4),
    .round_pulse (round_pulse4),
    .scores      (scores4),
    .match_over  (match_over4),
    .champion    (champion4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk2(input string tag, input logic [1:0] w, input logic p,
                      input logic [3:0] s, input logic mo, input logic ch);
    check({tag, ".winner"}, 32'(winner), 32'(w));
    check({tag, ".pulse"},  32'(round_pulse), 32'(p));
    check({tag, ".scores"}, 32'(scores), 32'(s));
    check({tag, ".over"},   32'(match_over), 32'(mo));
    check({tag, ".champ"},  32'(champion), 32'(ch));
  endtask

  task automatic chk4(input string tag, input logic [3:0] w, input logic p,
                      input logic [7:0] s, input logic mo, input logic [1:0] ch);
    check({tag, ".winner"}, 32'(winner4), 32'(w));
    check({tag, ".pulse"},  32'(round_pulse4), 32'(p));
    check({tag, ".scores"}, 32'(scores4), 32'(s));
    check({tag, ".over"},   32'(match_over4), 32'(mo));
    check({tag, ".champ"},  32'(champion4), 32'(ch));
  endtask

  initial begin
    rst = 1'b1; new_match = 1'b0; state = 3'd0;
    rst4 = 1'b1; new_match4 = 1'b0; state4 = 4'd0;
    tick(); tick();
    chk2("reset", 2'b00, 1'b0, 4'h0, 1'b0, 1'b0);
    chk4("reset4", 4'h0, 1'b0, 8'h00, 1'b0, 2'd0);
    rst = 1'b0; rst4 = 1'b0;
    tick();
    chk2("idle", 2'b00, 1'b0, 4'h0, 1'b0, 1'b0);

    // Player 0 win held four cycles scores once.
    state = 3'd5; tick();
    chk2("p0_hold1", 2'b01, 1'b1, 4'h1, 1'b0, 1'b0);
    tick();
    chk2("p0_hold2", 2'b01, 1'b0, 4'h1, 1'b0, 1'b0);
    tick(); tick();
    chk2("p0_hold4", 2'b01, 1'b0, 4'h1, 1'b0, 1'b0);
    state = 3'd0; tick();
    chk2("p0_leave", 2'b00, 1'b0, 4'h1, 1'b0, 1'b0);

    // Three separate player-1 episodes take the match.
    state = 3'd6; tick();
    chk2("p1_ep1", 2'b10, 1'b1, 4'h5, 1'b0, 1'b0);
    state = 3'd0; tick();
    state = 3'd6; tick();
    chk2("p1_ep2", 2'b10, 1'b1, 4'h9, 1'b0, 1'b0);
    state = 3'd0; tick();
    state = 3'd6; tick();
    chk2("p1_ep3", 2'b10, 1'b1, 4'hD, 1'b1, 1'b1);
    state = 3'd0; tick();
    chk2("over_idle", 2'b00, 1'b0, 4'hD, 1'b1, 1'b1);
    state = 3'd5; tick();
    chk2("over_frozen", 2'b01, 1'b0, 4'hD, 1'b1, 1'b1);
    state = 3'd0; tick();

    // New match, then 5 -> 6 directly scores only player 0.
    new_match = 1'b1; tick();
    chk2("newmatch", 2'b00, 1'b0, 4'h0, 1'b0, 1'b0);
    new_match = 1'b0;
    state = 3'd5; tick();
    chk2("swap_5", 2'b01, 1'b1, 4'h1, 1'b0, 1'b0);
    state = 3'd6; tick();
    chk2("swap_6", 2'b10, 1'b0, 4'h1, 1'b0, 1'b0);
    state = 3'd0; tick();
    chk2("swap_0", 2'b00, 1'b0, 4'h1, 1'b0, 1'b0);

    // Build 2/1, then new_match coincident with a fresh win code.
    state = 3'd5; tick(); state = 3'd0; tick();
    state = 3'd6; tick(); state = 3'd0; tick();
    chk2("score_2_1", 2'b00, 1'b0, 4'h6, 1'b0, 1'b0);
    state = 3'd5; new_match = 1'b1; tick();
    chk2("nm_win", 2'b01, 1'b0, 4'h0, 1'b0, 1'b0);
    new_match = 1'b0; tick();
    chk2("nm_hold", 2'b01, 1'b0, 4'h0, 1'b0, 1'b0);
    state = 3'd0; tick();
    state = 3'd5; tick();
    chk2("nm_reenter", 2'b01, 1'b1, 4'h1, 1'b0, 1'b0);
    state = 3'd0; tick();

    // Reset overrides new_match and an active win code.
    rst = 1'b1; new_match = 1'b1; state = 3'd6; tick();
    chk2("rst_override", 2'b00, 1'b0, 4'h0, 1'b0, 1'b0);
    rst = 1'b0; new_match = 1'b0; state = 3'd0; tick();

    // Four-player instance: player 3 wins a two-round match.
    state4 = 4'd11; tick();
    chk4("q_ep1", 4'b1000, 1'b1, 8'h40, 1'b0, 2'd0);
    state4 = 4'd0; tick();
    state4 = 4'd11; tick();
    chk4("q_ep2", 4'b1000, 1'b1, 8'h80, 1'b1, 2'd3);
    state4 = 4'd0; tick();
    state4 = 4'd9; tick();
    chk4("q_over", 4'b0010, 1'b0, 8'h80, 1'b1, 2'd3);
    state4 = 4'd0; new_match4 = 1'b1; tick();
    new_match4 = 1'b0;
    state4 = 4'd9; tick();
    chk4("q_p1", 4'b0010, 1'b1, 8'h04, 1'b0, 2'd0);
    state4 = 4'd0; tick();
    rst4 = 1'b1; new_match4 = 1'b1; state4 = 4'd10; tick();
    chk4("q_rst", 4'h0, 1'b0, 8'h00, 1'b0, 2'd0);
    rst4 = 1'b0; new_match4 = 1'b0; tick();
    chk4("q_after_rst", 4'b0100, 1'b1, 8'h10, 1'b0, 2'd0);
    state4 = 4'd12; tick();
    chk4("q_nonwin", 4'h0, 1'b0, 8'h10, 1'b0, 2'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
